// File: rtl/zc_track_pkg.sv
// Shared types and constants for the I/Q zero-crossing track controller.
// State encoding is visible on the state port, so the values are fixed.
package zc_track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_CAL  = 2'd2,
        ST_RUN  = 2'd3
    } zc_state_e;

    localparam int MAX_LOG_CAL_DEFAULT = 24;
    localparam int RECAL_W             = 16;

    // Calibration exponent limited to the supported maximum.
    function automatic logic [5:0] clamp_log(input logic [5:0] log_len, input int max_log);
        return (log_len > 6'(max_log)) ? 6'(max_log) : log_len;
    endfunction

endpackage

// File: rtl/zc_report_merge.sv
// Holds one I and one Q cycles-per-second report and emits them as a
// two-beat stream packet (I first, Q last); flush aborts everything.
module zc_report_merge
    import zc_track_pkg::*;
#(
    parameter int COUNTER_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [COUNTER_SIZE-1:0] cps_i_tdata,
    input  logic                    cps_i_tvalid,
    output logic                    cps_i_tready,
    input  logic [COUNTER_SIZE-1:0] cps_q_tdata,
    input  logic                    cps_q_tvalid,
    output logic                    cps_q_tready,
    output logic [COUNTER_SIZE-1:0] m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready
);

    logic [COUNTER_SIZE-1:0] hold_i, hold_q;
    logic full_i, full_q, full_i_d, full_q_d;
    logic take_i, take_q, beat, pkt_done;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        take_i   = enable && !flush && cps_i_tvalid && cps_i_tready;
        take_q   = enable && !flush && cps_q_tvalid && cps_q_tready;
        beat     = m_tvalid && m_tready;
        pkt_done = beat && m_tlast;
        full_i_d = full_i;
        full_q_d = full_q;
        if (flush || pkt_done) begin
            full_i_d = 1'b0;
            full_q_d = 1'b0;
        end else begin
            if (take_i) full_i_d = 1'b1;
            if (take_q) full_q_d = 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the holding registers are reset as well; they are plain flops, not a RAM.
            hold_i       <= '0;
            hold_q       <= '0;
            full_i       <= 1'b0;
            full_q       <= 1'b0;
            cps_i_tready <= 1'b0;
            cps_q_tready <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
        end else begin
            full_i       <= full_i_d;
            full_q       <= full_q_d;
            // Ready is registered from next-cycle fullness, so it is high only inside RUN.
            cps_i_tready <= !flush && !full_i_d;
            cps_q_tready <= !flush && !full_q_d;

            if (flush) begin
                hold_i <= '0;
                hold_q <= '0;
            end else begin
                if (take_i) hold_i <= cps_i_tdata;
                if (take_q) hold_q <= cps_q_tdata;
            end

            if (flush) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end else if (!m_tvalid) begin
                if (full_i && full_q) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= hold_i;
                    m_tlast  <= 1'b0;
                end
            end else if (beat) begin
                if (!m_tlast) begin
                    m_tdata <= hold_q;
                    m_tlast <= 1'b1;
                end else begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/zc_track_controller.sv
// Clear/calibrate/run sequencer for the I/Q zero-crossing detectors with
// loss-of-signal recalibration and merged per-PPS report output.
module zc_track_controller
    import zc_track_pkg::*;
#(
    parameter int COUNTER_SIZE = 32,
    parameter int TIMEOUT_W    = 32,
    parameter int MAX_LOG_CAL  = MAX_LOG_CAL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [5:0]              log_cal_len,
    input  logic [TIMEOUT_W-1:0]    timeout,
    input  logic                    sample_valid,
    input  logic                    zc_event_i,
    input  logic                    zc_event_q,
    output logic                    det_clear,
    output logic                    det_init_cal,
    input  logic [COUNTER_SIZE-1:0] cps_i_tdata,
    input  logic [COUNTER_SIZE-1:0] cps_q_tdata,
    input  logic                    cps_i_tvalid,
    input  logic                    cps_q_tvalid,
    output logic                    cps_i_tready,
    output logic                    cps_q_tready,
    output logic [COUNTER_SIZE-1:0] m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [1:0]              state,
    output logic [RECAL_W-1:0]      recal_count
);

    // One spare bit lets cal_cnt step once past 2^MAX_LOG_CAL on the exit edge.
    localparam int CAL_W = MAX_LOG_CAL + 1;

    zc_state_e            state_q, state_d;
    logic [CAL_W-1:0]     cal_cnt, cal_len;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic zc_event, timeout_hit, cal_entry, run_entry;

    always_comb begin
        cal_len     = CAL_W'(1) << clamp_log(log_cal_len, MAX_LOG_CAL);
        zc_event    = zc_event_i | zc_event_q;
        timeout_hit = (timeout != '0) && !zc_event && (to_cnt == timeout - TIMEOUT_W'(1));
        state_d     = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_CLR;
                ST_CLR:  state_d = ST_CAL;
                ST_CAL:  if (cal_cnt == cal_len) state_d = ST_RUN;
                ST_RUN:  if (timeout_hit) state_d = ST_CLR;
                default: state_d = ST_IDLE;
            endcase
        end
        cal_entry = (state_d == ST_CAL) && (state_q != ST_CAL);
        run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            det_clear    <= 1'b0;
            det_init_cal <= 1'b0;
            cal_cnt      <= '0;
            to_cnt       <= '0;
            recal_count  <= '0;
        end else begin
            state_q      <= state_d;
            det_clear    <= (state_d == ST_CLR);
            det_init_cal <= cal_entry;

            if (stop || cal_entry)
                cal_cnt <= '0;
            else if (state_q == ST_CAL && sample_valid)
                cal_cnt <= cal_cnt + CAL_W'(1);

            if (stop || run_entry || zc_event)
                to_cnt <= '0;
            else if (state_q == ST_RUN)
                to_cnt <= to_cnt + TIMEOUT_W'(1);

            if (state_q == ST_RUN && state_d == ST_CLR && recal_count != '1)
                recal_count <= recal_count + RECAL_W'(1);
        end
    end

    assign state = state_q;

    // Any cycle that will not be spent in RUN flushes the report path.
    zc_report_merge #(
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_merge (
        .clk          (clk),
        .reset        (reset),
        .enable       (state_q == ST_RUN),
        .flush        (state_d != ST_RUN),
        .cps_i_tdata  (cps_i_tdata),
        .cps_i_tvalid (cps_i_tvalid),
        .cps_i_tready (cps_i_tready),
        .cps_q_tdata  (cps_q_tdata),
        .cps_q_tvalid (cps_q_tvalid),
        .cps_q_tready (cps_q_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready)
    );

endmodule

// File: tb/tb_zc_track_controller.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the controller.
module tb_zc_track_controller;

    localparam int CS   = 32;
    localparam int TW   = 32;
    localparam int MAXL = 24;

    logic          clk = 1'b0;
    logic          reset, start, stop, sample_valid, zc_event_i, zc_event_q, m_tready;
    logic [5:0]    log_cal_len;
    logic [TW-1:0] timeout;
    logic [CS-1:0] cps_i_tdata, cps_q_tdata;
    logic          cps_i_tvalid, cps_q_tvalid;
    logic          det_clear, det_init_cal, cps_i_tready, cps_q_tready, m_tvalid, m_tlast;
    logic [CS-1:0] m_tdata;
    logic [1:0]    state;
    logic [15:0]   recal_count;

    always #5 clk = ~clk;

    zc_track_controller #(
        .COUNTER_SIZE (CS),
        .TIMEOUT_W    (TW),
        .MAX_LOG_CAL  (MAXL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .log_cal_len  (log_cal_len),
        .timeout      (timeout),
        .sample_valid (sample_valid),
        .zc_event_i   (zc_event_i),
        .zc_event_q   (zc_event_q),
        .det_clear    (det_clear),
        .det_init_cal (det_init_cal),
        .cps_i_tdata  (cps_i_tdata),
        .cps_q_tdata  (cps_q_tdata),
        .cps_i_tvalid (cps_i_tvalid),
        .cps_q_tvalid (cps_q_tvalid),
        .cps_i_tready (cps_i_tready),
        .cps_q_tready (cps_q_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .state        (state),
        .recal_count  (recal_count)
    );

    int     n_vec = 0;
    int     n_bad = 0;
    longint cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural model: phase, sample count since CAL entry, start of the
    // current quiet interval, and the packet as a queue of pending beats.
    int            ms;
    bit            m_clr, m_init, m_tri, m_trq, m_v, m_l, fi, fq;
    logic [CS-1:0] m_d, hi, hq;
    int unsigned   m_recal;
    longint        samples, quiet_from;
    logic [CS-1:0] beats[$];

    task automatic model_step();
        int nxt, l;
        bit ev, flush, acc_i, acc_q;
        if (reset) begin
            ms = 0; m_clr = 0; m_init = 0; m_tri = 0; m_trq = 0; m_v = 0; m_l = 0;
            fi = 0; fq = 0; m_d = '0; hi = '0; hq = '0; m_recal = 0;
            samples = 0; quiet_from = 0; beats.delete();
            return;
        end
        ev  = zc_event_i || zc_event_q;
        l   = (log_cal_len > MAXL) ? MAXL : int'(log_cal_len);
        nxt = ms;
        if (stop) nxt = 0;
        else if (ms == 0 && start) nxt = 1;
        else if (ms == 1) nxt = 2;
        else if (ms == 2 && samples == (longint'(1) << l)) nxt = 3;
        else if (ms == 3 && timeout != 0 && !ev && (cyc - quiet_from) == longint'(timeout) - 1) nxt = 1;

        if (ms == 2 && sample_valid) samples++;
        if (nxt == 2 && ms != 2) samples = 0;
        if (ms == 3 && ev) quiet_from = cyc + 1;
        if (nxt == 3 && ms != 3) quiet_from = cyc + 1;
        if (ms == 3 && nxt == 1 && m_recal < 32'hFFFF) m_recal++;

        flush = (nxt != 3);
        if (flush) begin
            fi = 0; fq = 0; m_v = 0; m_l = 0; beats.delete();
        end else begin
            acc_i = (ms == 3) && cps_i_tvalid && m_tri;
            acc_q = (ms == 3) && cps_q_tvalid && m_trq;
            if (m_v && m_tready) begin
                if (beats.size() != 0) begin
                    m_d = beats.pop_front();
                    m_l = 1;
                end else begin
                    m_v = 0; m_l = 0; fi = 0; fq = 0;
                end
            end else if (!m_v && fi && fq) begin
                beats.push_back(hq);
                m_d = hi; m_v = 1; m_l = 0;
            end
            if (acc_i) begin hi = cps_i_tdata; fi = 1; end
            if (acc_q) begin hq = cps_q_tdata; fq = 1; end
        end
        m_tri  = !flush && !fi;
        m_trq  = !flush && !fq;
        m_clr  = (nxt == 1);
        m_init = (nxt == 2 && ms != 2);
        ms     = nxt;
    endtask

    task automatic compare_model();
        check("state", 64'(state), 64'(ms));
        check("det_clear", 64'(det_clear), 64'(m_clr));
        check("det_init_cal", 64'(det_init_cal), 64'(m_init));
        check("cps_i_tready", 64'(cps_i_tready), 64'(m_tri));
        check("cps_q_tready", 64'(cps_q_tready), 64'(m_trq));
        check("m_tvalid", 64'(m_tvalid), 64'(m_v));
        check("m_tlast", 64'(m_tlast), 64'(m_l));
        if (m_v) check("m_tdata", 64'(m_tdata), 64'(m_d));
        check("recal_count", 64'(recal_count), 64'(m_recal));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        compare_model();
    endtask

    // Upstream sources drop valid after a handshake in the cycle just ended.
    task automatic tick_src();
        bit hs_i, hs_q;
        hs_i = cps_i_tvalid && cps_i_tready;
        hs_q = cps_q_tvalid && cps_q_tready;
        tick();
        if (hs_i) cps_i_tvalid = 1'b0;
        if (hs_q) cps_q_tvalid = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, output longint at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick_src();
            if (state == 2'(s)) begin
                at = cyc;
                break;
            end
        end
    endtask

    logic [CS-1:0] got_d[$];
    logic          got_l[$];

    task automatic collect(input int n);
        got_d.delete();
        got_l.delete();
        for (int i = 0; i < n; i++) begin
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_l.push_back(m_tlast);
            end
            tick_src();
        end
        while (got_d.size() < 4) begin
            got_d.push_back('x);
            got_l.push_back(1'bx);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 64'(state), 64'(0));
        check({tag, "_det_clear"}, 64'(det_clear), 64'(0));
        check({tag, "_det_init_cal"}, 64'(det_init_cal), 64'(0));
        check({tag, "_tready"}, 64'({cps_i_tready, cps_q_tready}), 64'(0));
        check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
        check({tag, "_m_tlast"}, 64'(m_tlast), 64'(0));
        check({tag, "_m_tdata"}, 64'(m_tdata), 64'(0));
        check({tag, "_recal"}, 64'(recal_count), 64'(0));
    endtask

    initial begin
        longint t_init, t_run, t_clr, r;
        reset = 1; start = 0; stop = 0; sample_valid = 0; zc_event_i = 0; zc_event_q = 0;
        m_tready = 1; log_cal_len = 6'd4; timeout = '0;
        cps_i_tdata = '0; cps_q_tdata = '0; cps_i_tvalid = 0; cps_q_tvalid = 0;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 0;
        tick();

        // Calibration with L=4 and continuous samples.
        sample_valid = 1; start = 1;
        tick();
        start = 0;
        check("clr_at_t1", 64'(det_clear), 64'(1));
        tick();
        check("init_cal_at_t2", 64'(det_init_cal), 64'(1));
        t_init = cyc;
        wait_state(3, 100, t_run);
        check("run_latency_L4", 64'(t_run - t_init), 64'(1 + (1 << 4)));

        // L=0: a single sample in the entry cycle completes calibration.
        stop = 1; tick(); stop = 0;
        sample_valid = 0; log_cal_len = 6'd0; start = 1;
        tick();
        start = 0;
        tick();
        check("init_cal_L0", 64'(det_init_cal), 64'(1));
        t_init = cyc;
        sample_valid = 1;
        tick();
        sample_valid = 0;
        wait_state(3, 20, t_run);
        check("run_latency_L0", 64'(t_run - t_init), 64'(2));

        // Report merge: Q arrives first, I second, no backpressure.
        cps_q_tdata = 32'd5; cps_q_tvalid = 1;
        tick_src(); tick_src();
        cps_i_tdata = 32'hFFFF_FFFB; cps_i_tvalid = 1;
        collect(10);
        check("pkt1_beat0", 64'(got_d[0]), 64'(32'hFFFF_FFFB));
        check("pkt1_last0", 64'(got_l[0]), 64'(0));
        check("pkt1_beat1", 64'(got_d[1]), 64'(5));
        check("pkt1_last1", 64'(got_l[1]), 64'(1));

        // Backpressure: stalled packet stays stable, a third report waits.
        m_tready = 0;
        cps_i_tdata = 32'd9; cps_q_tdata = 32'd7; cps_i_tvalid = 1; cps_q_tvalid = 1;
        tick_src();
        cps_i_tdata = 32'd11; cps_q_tdata = 32'd13; cps_i_tvalid = 1; cps_q_tvalid = 1;
        tick_src();
        for (int i = 0; i < 10; i++) begin
            tick_src();
            check("stall_valid", 64'(m_tvalid), 64'(1));
            check("stall_data", 64'(m_tdata), 64'(9));
            check("stall_ready_i", 64'(cps_i_tready), 64'(0));
        end
        m_tready = 1;
        collect(30);
        check("bp_beat0", 64'(got_d[0]), 64'(9));
        check("bp_beat1", 64'(got_d[1]), 64'(7));
        check("bp_beat2", 64'(got_d[2]), 64'(11));
        check("bp_beat3", 64'(got_d[3]), 64'(13));
        check("bp_lasts", 64'({got_l[0], got_l[1], got_l[2], got_l[3]}), 64'(4'b0101));

        // Timeout: no events for 100 cycles after RUN entry.
        stop = 1; tick(); stop = 0;
        timeout = 100; log_cal_len = 6'd0; sample_valid = 1; start = 1;
        tick();
        start = 0;
        wait_state(3, 20, r);
        wait_state(1, 150, t_clr);
        check("timeout_latency", 64'(t_clr - r), 64'(100));
        check("recal_after_timeout", 64'(recal_count), 64'(1));
        wait_state(3, 20, r);
        check("recal_completes", 64'(state), 64'(3));
        while (cyc < r + 99) tick_src();
        zc_event_i = 1;
        tick_src();
        zc_event_i = 0;
        check("event_suppresses", 64'(state), 64'(3));
        wait_state(1, 150, t_clr);
        check("timeout_after_event", 64'(t_clr - r), 64'(200));
        timeout = 0;
        wait_state(3, 20, r);
        repeat (300) tick_src();
        check("no_timeout_when_0", 64'(state), 64'(3));
        check("recal_held", 64'(recal_count), 64'(2));

        // Stop after beat 0 is accepted aborts the packet.
        cps_i_tdata = 32'h11; cps_q_tdata = 32'h22; cps_i_tvalid = 1; cps_q_tvalid = 1;
        for (int i = 0; i < 20; i++) begin
            tick_src();
            if (m_tvalid && !m_tlast) break;
        end
        tick_src();
        check("beat1_presented", 64'(m_tlast), 64'(1));
        stop = 1;
        tick_src();
        stop = 0;
        check("abort_valid", 64'(m_tvalid), 64'(0));
        check("abort_state", 64'(state), 64'(0));
        check("abort_tready", 64'({cps_i_tready, cps_q_tready}), 64'(0));
        log_cal_len = 6'd4; sample_valid = 1; start = 1;
        tick();
        start = 0;
        check("restart_clr", 64'(det_clear), 64'(1));
        tick();
        t_init = cyc;
        wait_state(3, 100, t_run);
        check("restart_latency", 64'(t_run - t_init), 64'(17));

        // Reset mid-CAL, then stop and start together.
        stop = 1; tick(); stop = 0;
        start = 1; tick(); start = 0;
        tick(); tick();
        reset = 1; tick(); reset = 0;
        check_reset_values("midcal_rst");
        stop = 1; start = 1;
        tick();
        stop = 0; start = 0;
        check("stop_wins", 64'(state), 64'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(799) == 0);
            stop         = ($urandom_range(149) == 0);
            start        = ($urandom_range(19) == 0);
            sample_valid = ($urandom_range(3) != 0);
            zc_event_i   = ($urandom_range(39) == 0);
            zc_event_q   = ($urandom_range(39) == 0);
            m_tready     = ($urandom_range(9) < 7);
            if (state == 2'd0) begin
                timeout     = ($urandom_range(3) == 0) ? '0 : TW'($urandom_range(60, 2));
                log_cal_len = ($urandom_range(9) == 0) ? 6'd40 : 6'($urandom_range(4));
            end
            if (!cps_i_tvalid && $urandom_range(3) == 0) begin
                cps_i_tvalid = 1; cps_i_tdata = $urandom;
            end
            if (!cps_q_tvalid && $urandom_range(3) == 0) begin
                cps_q_tvalid = 1; cps_q_tdata = $urandom;
            end
            tick_src();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
